// File: rtl/coin_key_filter_pkg.sv
// Shared definitions for the coin key debounce filters: state encoding and default
// stability window.
package coin_key_filter_pkg;

    // 20 ms at 50 MHz.
    localparam int unsigned CNT_MAX_DEFAULT = 999_999;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        HELD       = 2'd2,
        REL_FILT   = 2'd3
    } filt_state_t;

    // True once a level has been stable for cnt_max clocks; the entry clock of a filter
    // state counts as the first stable clock, so the counter lags the window by one.
    function automatic logic window_done(input int unsigned cnt, input int unsigned cnt_max);
        return (cnt + 32'd2) >= cnt_max;
    endfunction

endpackage

// File: rtl/coin_key_filter_if.sv
// Raw coin switches in, accepted-coin pulses out.
interface coin_key_filter_if;

    logic key_half;
    logic key_one;
    logic po_money_half;
    logic po_money_one;

    // master: coin mechanism plus vending FSM side; slave: the filter block.
    modport master (
        output key_half,
        output key_one,
        input  po_money_half,
        input  po_money_one
    );

    modport slave (
        input  key_half,
        input  key_one,
        output po_money_half,
        output po_money_one
    );

endinterface

// File: rtl/key_filter.sv
// One debounced coin switch: two-flop synchronizer, press/release filter FSM and a
// one-clock accept strobe on every accepted press. CNT_MAX is expected to be >= 2.
module key_filter
    import coin_key_filter_pkg::*;
#(
    parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key,
    output logic accept
);

    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    logic             key_meta;
    logic             key_sync;
    filt_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             stable_done;

    // Synchronizer resets to the released level so reset never looks like a press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key;
            key_sync <= key_meta;
        end
    end

    always_comb begin
        cnt_inc     = (32'(cnt) == CNT_MAX) ? cnt : cnt + 1'b1;
        stable_done = window_done(32'(cnt), CNT_MAX);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            accept <= 1'b0;
        end else begin
            accept <= 1'b0;
            case (state)
                IDLE: begin
                    if (!key_sync) begin
                        state <= PRESS_FILT;
                        cnt   <= '0;
                    end
                end
                PRESS_FILT: begin
                    if (key_sync) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (stable_done) begin
                        state  <= HELD;
                        cnt    <= '0;
                        accept <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                HELD: begin
                    if (key_sync) begin
                        state <= REL_FILT;
                        cnt   <= '0;
                    end
                end
                REL_FILT: begin
                    if (!key_sync) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (stable_done) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/coin_key_filter.sv
// Two debounced coin switches merged into mutually exclusive registered coin pulses;
// colliding accepts are serialised through one-entry pending flags, oldest first.
module coin_key_filter
    import coin_key_filter_pkg::*;
#(
    parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    coin_key_filter_if.slave         coin_bus
);

    logic acc_half;
    logic acc_one;
    logic pend_half;
    logic pend_one;
    logic half_q;
    logic one_q;

    key_filter #(
        .CNT_MAX (CNT_MAX)
    ) u_filt_half (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key       (coin_bus.key_half),
        .accept    (acc_half)
    );

    key_filter #(
        .CNT_MAX (CNT_MAX)
    ) u_filt_one (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key       (coin_bus.key_one),
        .accept    (acc_one)
    );

    // Pending strobes go out before fresh ones; among fresh strobes one-unit wins.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            half_q    <= 1'b0;
            one_q     <= 1'b0;
            pend_half <= 1'b0;
            pend_one  <= 1'b0;
        end else if (pend_half) begin
            half_q    <= 1'b1;
            one_q     <= 1'b0;
            pend_half <= acc_half;
            pend_one  <= pend_one | acc_one;
        end else if (pend_one) begin
            half_q    <= 1'b0;
            one_q     <= 1'b1;
            pend_half <= acc_half;
            pend_one  <= acc_one;
        end else if (acc_one) begin
            half_q    <= 1'b0;
            one_q     <= 1'b1;
            pend_half <= acc_half;
            pend_one  <= 1'b0;
        end else begin
            half_q    <= acc_half;
            one_q     <= 1'b0;
            pend_half <= 1'b0;
            pend_one  <= 1'b0;
        end
    end

    assign coin_bus.po_money_half = half_q;
    assign coin_bus.po_money_one  = one_q;

endmodule

// File: tb/tb_coin_key_filter.sv
// Directed and randomised checks of coin_key_filter against a run-length debounce
// model feeding a coin FIFO.
module tb_coin_key_filter;

    localparam int unsigned CNT = 4;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;

    coin_key_filter_if bus ();

    coin_key_filter #(
        .CNT_MAX (CNT)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .coin_bus  (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    // Reference model: debounced level per key plus a run length of disagreeing samples.
    logic lvl_h, lvl_o;
    int   run_h, run_o;
    int   due_h[$];
    int   due_o[$];
    int   coin_q[$];
    logic exp_h, exp_o;
    int   n_half, n_one, last_half_edge, last_one_edge;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void model_clear();
        lvl_h = 1'b1;
        lvl_o = 1'b1;
        run_h = 0;
        run_o = 0;
        due_h.delete();
        due_o.delete();
        coin_q.delete();
        exp_h = 1'b0;
        exp_o = 1'b0;
    endfunction

    // A press is accepted once CNT consecutive raw samples disagree with the level.
    function automatic void filt(input logic v, inout logic lv, inout int rn,
                                 output logic acc);
        acc = 1'b0;
        if (v !== lv) begin
            rn++;
            if (rn == int'(CNT)) begin
                lv  = v;
                rn  = 0;
                acc = (v == 1'b0);
            end
        end else begin
            rn = 0;
        end
    endfunction

    function automatic void model_edge();
        logic a;
        int   c;
        if (due_o.size() > 0 && due_o[0] == cyc) begin
            void'(due_o.pop_front());
            coin_q.push_back(1);
        end
        if (due_h.size() > 0 && due_h[0] == cyc) begin
            void'(due_h.pop_front());
            coin_q.push_back(0);
        end
        filt(bus.key_half, lvl_h, run_h, a);
        if (a) due_h.push_back(cyc + 3);
        filt(bus.key_one, lvl_o, run_o, a);
        if (a) due_o.push_back(cyc + 3);
        exp_h = 1'b0;
        exp_o = 1'b0;
        if (coin_q.size() > 0) begin
            c = coin_q.pop_front();
            if (c == 1) exp_o = 1'b1;
            else exp_h = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        cyc++;
        if (sys_rst_n) model_edge();
        else begin
            exp_h = 1'b0;
            exp_o = 1'b0;
        end
        @(negedge sys_clk);
        chk("po_money_half", int'(bus.po_money_half), int'(exp_h));
        chk("po_money_one", int'(bus.po_money_one), int'(exp_o));
        chk("exclusive", int'(bus.po_money_half & bus.po_money_one), 0);
        if (bus.po_money_half) begin
            n_half++;
            last_half_edge = cyc;
        end
        if (bus.po_money_one) begin
            n_one++;
            last_one_edge = cyc;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int n);
        sys_rst_n = 1'b0;
        model_clear();
        ticks(n);
        sys_rst_n = 1'b1;
    endtask

    int t0, h0, o0;
    int rem_h, rem_o;

    initial begin
        n_half = 0;
        n_one = 0;
        last_half_edge = -1;
        last_one_edge = -1;
        model_clear();

        // Reset with both keys pressed, then idle released.
        bus.key_half = 1'b0;
        bus.key_one = 1'b0;
        @(negedge sys_clk);
        chk("reset_half", int'(bus.po_money_half), 0);
        chk("reset_one", int'(bus.po_money_one), 0);
        ticks(2);
        bus.key_half = 1'b1;
        bus.key_one = 1'b1;
        do_reset(1);
        ticks(10);

        // Clean press.
        h0 = n_half;
        bus.key_half = 1'b0;
        t0 = cyc + 1;
        ticks(20);
        bus.key_half = 1'b1;
        ticks(12);
        chk("clean_count", n_half - h0, 1);
        chk("clean_latency", last_half_edge - t0, 6);

        // Bounce then stable press.
        o0 = n_one;
        for (int i = 0; i < 10; i++) begin
            bus.key_one = ((i / 2) % 2 == 1);
            if (i == 8) t0 = cyc + 1;
            tick();
        end
        ticks(15);
        bus.key_one = 1'b1;
        ticks(12);
        chk("bounce_count", n_one - o0, 1);
        chk("bounce_latency", last_one_edge - t0, 6);

        // Simultaneous press.
        h0 = n_half;
        o0 = n_one;
        bus.key_half = 1'b0;
        bus.key_one = 1'b0;
        t0 = cyc + 1;
        ticks(15);
        bus.key_half = 1'b1;
        bus.key_one = 1'b1;
        ticks(12);
        chk("simul_one_latency", last_one_edge - t0, 6);
        chk("simul_half_latency", last_half_edge - t0, 7);
        chk("simul_count", (n_half - h0) + (n_one - o0), 2);

        // Reset while the press counter is at 2, key kept held through release.
        h0 = n_half;
        bus.key_half = 1'b0;
        ticks(5);
        do_reset(2);
        t0 = cyc + 1;
        ticks(15);
        chk("rstmid_count", n_half - h0, 1);
        chk("rstmid_latency", last_half_edge - t0, 6);
        bus.key_half = 1'b1;
        ticks(12);

        // Held key with a release too short to complete the release filter.
        h0 = n_half;
        bus.key_half = 1'b0;
        ticks(50);
        bus.key_half = 1'b1;
        ticks(2);
        bus.key_half = 1'b0;
        ticks(20);
        bus.key_half = 1'b1;
        ticks(12);
        chk("held_count", n_half - h0, 1);

        // Random bouncy segments on both keys with occasional resets.
        rem_h = 0;
        rem_o = 0;
        for (int i = 0; i < 1500; i++) begin
            if (rem_h == 0) begin
                bus.key_half = 1'($urandom_range(0, 1));
                rem_h = $urandom_range(1, 10);
            end
            if (rem_o == 0) begin
                bus.key_one = 1'($urandom_range(0, 1));
                rem_o = $urandom_range(1, 10);
            end
            rem_h--;
            rem_o--;
            if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 3));
            else tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
